// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Results are presented on a valid/ready port; unaccepted results are overwritten and flagged.
module period_meter #(
  parameter int W    = 16,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         overflow,
  output logic         missed,
  output logic         valid,
  input  logic         ready
);

  // state   | meaning
  // IDLE    | disabled, counters cleared
  // ARM     | enabled, waiting for the first genuine rising edge
  // MEASURE | counting; every further rise closes a period and reports it
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [SYNC-1:0] sync_q;
  logic            s;
  logic            s_d;
  logic            rise;
  state_t          state;
  state_t          state_n;
  logic            start;
  logic            latch;
  logic [W-1:0]    cnt;
  logic [W-1:0]    hcnt;
  logic            sat;
  logic            xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~s_d;
  assign xfer = valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    latch   = 1'b0;
    case (state)
      IDLE:    if (en) state_n = ARM;
      ARM: begin
        if (rise) begin
          state_n = MEASURE;
          start   = 1'b1;
        end
      end
      MEASURE: if (rise) latch = 1'b1;
      default: state_n = IDLE;
    endcase
    // Disable overrides everything: the open measurement is simply dropped.
    if (!en) begin
      state_n = IDLE;
      start   = 1'b0;
      latch   = 1'b0;
    end
  end

  // The rise cycle itself is counted, so both counters restart at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
      sat  <= 1'b0;
    end else if (start || latch) begin
      cnt  <= CNT_ONE;
      hcnt <= CNT_ONE;
      sat  <= 1'b0;
    end else if (en && state == MEASURE) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      else                sat <= 1'b1;
      if (s && hcnt != CNT_MAX) hcnt <= hcnt + CNT_ONE;
    end else begin
      cnt  <= '0;
      hcnt <= '0;
      sat  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
      missed    <= 1'b0;
      valid     <= 1'b0;
    end else if (latch) begin
      period    <= cnt;
      high_time <= hcnt;
      overflow  <= sat;
      valid     <= 1'b1;
      // A result accepted on the same edge is not lost, so it clears rather than sets.
      if (valid && !ready) missed <= 1'b1;
      else if (xfer)       missed <= 1'b0;
    end else if (xfer) begin
      valid  <= 1'b0;
      missed <= 1'b0;
    end
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock, in cycles of the system clock. It sits on the receiving side of the clock-divider chain: it reconstructs the division ratio and duty cycle so the divider output can be checked in-system. Results are handed out through a valid/ready port.

## Interface
Parameters:
- `W`, default 16: width of the period and high-time counters and results.
- `SYNC`, default 2: number of synchronizer flops on `sig_in` (minimum 2).

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Clears all state immediately.
- `en`  in  1  measurement enable. Level-sensitive.
- `sig_in`  in  1  signal under test. Asynchronous to `clk`.
- `period`  out  W  cycles between two consecutive rising edges of `sig_in`.
- `high_time`  out  W  cycles `sig_in` was high within that period.
- `overflow`  out  1  the reported period saturated at 2^W-1.
- `missed`  out  1  at least one result was overwritten before it was accepted.
- `valid`  out  1  a result is present on `period`, `high_time` and `overflow`.
- `ready`  in  1  consumer accepts the result.

## Operation
- Synchronizer:
  - `sig_in` passes through `SYNC` flops; the last stage is `s`.
  - `s_d` is `s` delayed by one cycle.
  - `rise` = `s` & ~`s_d`.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE to ARM when `en`=1.
  - ARM to MEASURE on `rise`.
  - Any state to IDLE when `en`=0.
  - A signal that is already high at enable is not a rise. ARM waits for a genuine 0 to 1 transition.
- Counters `cnt` and `hcnt`:
  - On the `rise` that enters MEASURE: `cnt`<=1, `hcnt`<=1.
  - In MEASURE without `rise`: `cnt`<=`cnt`+1, saturating at 2^W-1 and setting an internal `sat` flag. `hcnt`<=`hcnt`+`s`, saturating.
  - In MEASURE with `rise`: `period`<=`cnt`, `high_time`<=`hcnt`, `overflow`<=`sat`, `valid`<=1. Then `cnt`<=1, `hcnt`<=1, `sat`<=0, and the FSM stays in MEASURE.
  - A steady input with period P and high time H reports exactly P and H. Requires P ≥ 2.
- Handshake:
  - A transfer occurs on a cycle with `valid`&`ready`.
  - `valid` falls after a transfer unless a new result is latched on the same edge. In that case the new result wins, `valid` stays 1 and `missed` is not set.
  - A new result arriving while `valid`=1 and `ready`=0 overwrites the outputs with the latest values and sets `missed`.
  - `missed` clears on the next transfer.
  - Output data is stable while `valid`=1 and `ready`=0, except when overwritten as above.
- `en`=0:
  - The in-progress measurement is discarded and counters are cleared.
  - A pending `valid` result is kept until it is accepted.
  - Re-enabling needs two fresh rises before the next `valid`.
- Reset values: `period`=0, `high_time`=0, `overflow`=0, `missed`=0, `valid`=0. State IDLE; `cnt`, `hcnt`, `sat` and all synchronizer flops 0.

## Timing
- A `sig_in` edge first sampled at edge t appears on `s` after edge t+SYNC-1. `rise` acts at edge t+SYNC.
- Result latency: `valid` rises at edge t2+SYNC, where t2 is the first sampling edge of the closing rise.
- Throughput is one result per input period. The consumer must accept within P cycles to avoid `missed`.
- Edge-position uncertainty is ±1 cycle per edge from synchronization. For a clean, clk-synchronous input, results are exact.
- `rst` deassertion is synchronized externally. The block's behaviour on its first edge after deassertion is the IDLE behaviour.

## Test plan
- Reset: assert `rst` mid-MEASURE with `valid`=1 -> all outputs 0 immediately, without waiting for a clock. After release, no `valid` until two rises.
- Divide-by-4 input (pattern 1,1,0,0 synchronous to `clk`), `en`=1, `ready`=1 -> first `valid` at SYNC edges after the second rise. `period`=4, `high_time`=2, `overflow`=0, one `valid` pulse every 4 cycles.
- Period-10 input with high for 3 -> `period`=10, `high_time`=3. Then a period-7 input with high for 6 -> `period`=7, `high_time`=6.
- W=4, period-20 input with high for 10 -> `period`=15, `high_time`=10, `overflow`=1. The next 8-cycle period reports 8 with `overflow`=0.
- Divide-by-4 input with `ready`=0 for 14 cycles:
  - `valid` stays 1 and `missed`=1.
  - Data holds the latest result.
  - A single `ready` pulse with no rise in that cycle -> `valid`=0 and `missed`=0 on the next edge.
- Drop `en` for 3 cycles mid-period with `sig_in` high at re-enable -> no `valid` until two genuine rises have occurred. The first result equals the true period.
